// File: rtl/sar_adc_pkg.sv
// Shared types and default sizes for the SAR ADC scan sequencer.
package sar_adc_pkg;

    localparam int SAR_NUM_CH = 4;
    localparam int SAR_CH_W   = 2;
    localparam int SAR_DATA_W = 10;

    // Scan controller states.
    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SELECT,
        ST_SETTLE,
        ST_START,
        ST_CONVERT,
        ST_STORE,
        ST_DONE
    } sar_state_t;

    // One tagged conversion result.
    typedef struct packed {
        logic [SAR_CH_W-1:0]   ch;
        logic [SAR_DATA_W-1:0] data;
        logic                  err;
    } sar_result_t;

endpackage

// File: rtl/sar_ch_picker.sv
// Lowest-set-bit finder over the pending channel mask.
module sar_ch_picker #(
    parameter int NUM_CH = 4,
    parameter int CH_W   = 2
) (
    input  logic [NUM_CH-1:0] mask,
    output logic [CH_W-1:0]   ch_idx,
    output logic              any_pending
);

    // Scan from the top down so the lowest set bit is the last one written.
    always_comb begin
        ch_idx      = '0;
        any_pending = 1'b0;
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            if (mask[i]) begin
                ch_idx      = CH_W'(i);
                any_pending = 1'b1;
            end
        end
    end

endmodule

// File: rtl/sar_adc_sequencer.sv
// Multi-channel scan controller: drives the analog mux and sample/hold,
// starts one SAR conversion per enabled channel in ascending order and
// returns each result tagged with its channel.
module sar_adc_sequencer
    import sar_adc_pkg::*;
#(
    parameter int NUM_CH         = SAR_NUM_CH,
    parameter int CH_W           = SAR_CH_W,
    parameter int DATA_W         = SAR_DATA_W,
    parameter int SETTLE_CYCLES  = 4,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              trig,
    input  logic              cont_mode,
    input  logic [NUM_CH-1:0] ch_enable,
    input  logic              sar_eoc,
    input  logic [DATA_W-1:0] sar_data,
    output logic [CH_W-1:0]   mux_sel,
    output logic              sample_hold,
    output logic              sar_start,
    output logic              busy,
    output logic              result_valid,
    output logic [CH_W-1:0]   result_ch,
    output logic [DATA_W-1:0] result_data,
    output logic              result_err,
    output logic              scan_done,
    output logic              overrun
);

    localparam int SET_W = $clog2(SETTLE_CYCLES + 1);
    localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);

    sar_state_t        state_reg;
    logic              first_reg;       // next SELECT starts a new scan
    logic [NUM_CH-1:0] pending_reg;
    logic [SET_W-1:0]  settle_cnt_reg;
    logic [TMO_W-1:0]  tmo_cnt_reg;
    logic              eoc_prev_reg;
    sar_result_t       result_reg;
    logic [CH_W-1:0]   mux_sel_reg;
    logic              sample_hold_reg;
    logic              sar_start_reg;
    logic              busy_reg;
    logic              result_valid_reg;
    logic              scan_done_reg;
    logic              overrun_reg;

    logic [NUM_CH-1:0] mask_src;
    logic [CH_W-1:0]   pick_ch;
    logic              pick_any;
    logic              eoc_rise;
    logic              tmo_hit;

    // At the first SELECT of a scan the live enable mask is used (and latched);
    // afterwards only the latched pending copy counts.
    assign mask_src = first_reg ? ch_enable : pending_reg;
    assign eoc_rise = sar_eoc & ~eoc_prev_reg;
    assign tmo_hit  = (tmo_cnt_reg + TMO_W'(1)) == TMO_W'(TIMEOUT_CYCLES);

    sar_ch_picker #(
        .NUM_CH (NUM_CH),
        .CH_W   (CH_W)
    ) u_picker (
        .mask        (mask_src),
        .ch_idx      (pick_ch),
        .any_pending (pick_any)
    );

    // Scan state machine with registered outputs, counters and eoc edge detect.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg        <= ST_IDLE;
            first_reg        <= 1'b0;
            pending_reg      <= '0;
            settle_cnt_reg   <= '0;
            tmo_cnt_reg      <= '0;
            eoc_prev_reg     <= 1'b0;
            result_reg       <= '0;
            mux_sel_reg      <= '0;
            sample_hold_reg  <= 1'b0;
            sar_start_reg    <= 1'b0;
            busy_reg         <= 1'b0;
            result_valid_reg <= 1'b0;
            scan_done_reg    <= 1'b0;
            overrun_reg      <= 1'b0;
        end else begin
            eoc_prev_reg     <= sar_eoc;
            sample_hold_reg  <= 1'b0;
            sar_start_reg    <= 1'b0;
            result_valid_reg <= 1'b0;
            scan_done_reg    <= 1'b0;

            if (trig && state_reg != ST_IDLE) begin
                overrun_reg <= 1'b1;
            end

            case (state_reg)
                ST_IDLE: begin
                    if (trig) begin
                        state_reg <= ST_SELECT;
                        first_reg <= 1'b1;
                        busy_reg  <= 1'b1;
                    end
                end
                ST_SELECT: begin
                    first_reg   <= 1'b0;
                    pending_reg <= mask_src;
                    if (pick_any) begin
                        mux_sel_reg     <= pick_ch;
                        settle_cnt_reg  <= '0;
                        sample_hold_reg <= 1'b1;
                        state_reg       <= ST_SETTLE;
                    end else begin
                        scan_done_reg <= 1'b1;
                        state_reg     <= ST_DONE;
                    end
                end
                ST_SETTLE: begin
                    if (settle_cnt_reg == SET_W'(SETTLE_CYCLES - 1)) begin
                        sar_start_reg <= 1'b1;
                        state_reg     <= ST_START;
                    end else begin
                        settle_cnt_reg  <= settle_cnt_reg + SET_W'(1);
                        sample_hold_reg <= 1'b1;
                    end
                end
                ST_START: begin
                    tmo_cnt_reg <= '0;
                    state_reg   <= ST_CONVERT;
                end
                ST_CONVERT: begin
                    // An edge in the timeout cycle still counts as a good result.
                    if (eoc_rise) begin
                        result_reg       <= '{ch: mux_sel_reg, data: sar_data, err: 1'b0};
                        result_valid_reg <= 1'b1;
                        state_reg        <= ST_STORE;
                    end else if (tmo_hit) begin
                        result_reg       <= '{ch: mux_sel_reg, data: '0, err: 1'b1};
                        result_valid_reg <= 1'b1;
                        state_reg        <= ST_STORE;
                    end else begin
                        tmo_cnt_reg <= tmo_cnt_reg + TMO_W'(1);
                    end
                end
                ST_STORE: begin
                    pending_reg[mux_sel_reg] <= 1'b0;
                    state_reg                <= ST_SELECT;
                end
                ST_DONE: begin
                    if (cont_mode) begin
                        first_reg <= 1'b1;
                        state_reg <= ST_SELECT;
                    end else begin
                        busy_reg  <= 1'b0;
                        state_reg <= ST_IDLE;
                    end
                end
                default: begin
                    busy_reg  <= 1'b0;
                    state_reg <= ST_IDLE;
                end
            endcase
        end
    end

    assign mux_sel      = mux_sel_reg;
    assign sample_hold  = sample_hold_reg;
    assign sar_start    = sar_start_reg;
    assign busy         = busy_reg;
    assign result_valid = result_valid_reg;
    assign result_ch    = result_reg.ch;
    assign result_data  = result_reg.data;
    assign result_err   = result_reg.err;
    assign scan_done    = scan_done_reg;
    assign overrun      = overrun_reg;

endmodule

// File: tb/tb_sar_adc_sequencer.sv
// Randomized self-checking bench for sar_adc_sequencer. A scan-level model
// predicts the cycle of every sar_start, result and scan_done from the
// channel mask and the core model's per-channel answer latency.
module tb_sar_adc_sequencer;
    import sar_adc_pkg::*;

    localparam int NUM_CH = 4;
    localparam int CH_W   = 2;
    localparam int DATA_W = 10;
    localparam int SETTLE = 4;
    localparam int TMO    = 64;

    logic              clk = 1'b0;
    logic              rst;
    logic              trig;
    logic              cont_mode;
    logic [NUM_CH-1:0] ch_enable;
    logic              sar_eoc;
    logic [DATA_W-1:0] sar_data;
    logic [CH_W-1:0]   mux_sel;
    logic              sample_hold;
    logic              sar_start;
    logic              busy;
    logic              result_valid;
    logic [CH_W-1:0]   result_ch;
    logic [DATA_W-1:0] result_data;
    logic              result_err;
    logic              scan_done;
    logic              overrun;

    sar_adc_sequencer #(
        .NUM_CH         (NUM_CH),
        .CH_W           (CH_W),
        .DATA_W         (DATA_W),
        .SETTLE_CYCLES  (SETTLE),
        .TIMEOUT_CYCLES (TMO)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .trig         (trig),
        .cont_mode    (cont_mode),
        .ch_enable    (ch_enable),
        .sar_eoc      (sar_eoc),
        .sar_data     (sar_data),
        .mux_sel      (mux_sel),
        .sample_hold  (sample_hold),
        .sar_start    (sar_start),
        .busy         (busy),
        .result_valid (result_valid),
        .result_ch    (result_ch),
        .result_data  (result_data),
        .result_err   (result_err),
        .scan_done    (scan_done),
        .overrun      (overrun)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=0x%0h exp=0x%0h (cyc %0d)", tag, got, exp, cyc);
        end
    endtask

    // Core model configuration: latency 0 means the core never answers.
    int                lat_tab [NUM_CH];
    logic [DATA_W-1:0] dat_tab [NUM_CH];
    bit                spur_en = 1'b0;

    // Observed events.
    int act_start_cyc[$], act_start_ch[$];
    int act_res_cyc[$], act_res_ch[$], act_res_data[$], act_res_err[$];
    int act_done[$], act_busy_fall[$], act_sh_rise[$];
    int sh_cnt;
    bit busy_prev, sh_prev;
    int raise_at = -1;

    // Expected events.
    int exp_start_cyc[$], exp_start_ch[$];
    int exp_res_cyc[$], exp_res_ch[$], exp_res_data[$], exp_res_err[$];
    int exp_done[$], exp_sh_rise[$];

    // Monitor plus SAR core model, both on the falling edge.
    always @(negedge clk) begin
        if (rst) begin
            raise_at  = -1;
            sar_eoc   = 1'b0;
            busy_prev = 1'b0;
            sh_prev   = 1'b0;
        end else begin
            if (sar_start) begin
                act_start_cyc.push_back(cyc);
                act_start_ch.push_back(int'(mux_sel));
                if (lat_tab[mux_sel] != 0) raise_at = cyc + lat_tab[mux_sel];
            end
            if (result_valid) begin
                act_res_cyc.push_back(cyc);
                act_res_ch.push_back(int'(result_ch));
                act_res_data.push_back(int'(result_data));
                act_res_err.push_back(int'(result_err));
            end
            if (scan_done) act_done.push_back(cyc);
            if (busy_prev && !busy) act_busy_fall.push_back(cyc);
            if (sample_hold) sh_cnt++;
            if (sample_hold && !sh_prev) act_sh_rise.push_back(cyc);
            busy_prev = busy;
            sh_prev   = sample_hold;

            if (sar_eoc) begin
                sar_eoc  = 1'b0;
                sar_data = DATA_W'($urandom);
            end else if (cyc == raise_at) begin
                sar_eoc  = 1'b1;
                sar_data = dat_tab[mux_sel];
                raise_at = -1;
            end else if (spur_en && sample_hold && $urandom_range(0, 3) == 0) begin
                sar_eoc  = 1'b1;
                sar_data = DATA_W'($urandom);
            end
        end
    end

    // One scan whose SELECT-entering edge follows the negedge at cycle c.
    task automatic model_scan(input int c, input logic [NUM_CH-1:0] m, output int done_cyc);
        int sel;
        int s;
        int r;
        sel = c + 1;
        for (int ch = 0; ch < NUM_CH; ch++) begin
            if (m[ch]) begin
                s = sel + 1 + SETTLE;
                exp_sh_rise.push_back(sel + 1);
                exp_start_cyc.push_back(s);
                exp_start_ch.push_back(ch);
                exp_res_ch.push_back(ch);
                if (lat_tab[ch] != 0) begin
                    r = s + lat_tab[ch] + 1;
                    exp_res_data.push_back(int'(dat_tab[ch]));
                    exp_res_err.push_back(0);
                end else begin
                    r = s + TMO + 1;
                    exp_res_data.push_back(0);
                    exp_res_err.push_back(1);
                end
                exp_res_cyc.push_back(r);
                sel = r + 1;
            end
        end
        done_cyc = sel + 1;
        exp_done.push_back(done_cyc);
    endtask

    task automatic clear_all();
        act_start_cyc.delete(); act_start_ch.delete();
        act_res_cyc.delete(); act_res_ch.delete(); act_res_data.delete(); act_res_err.delete();
        act_done.delete(); act_busy_fall.delete(); act_sh_rise.delete();
        exp_start_cyc.delete(); exp_start_ch.delete();
        exp_res_cyc.delete(); exp_res_ch.delete(); exp_res_data.delete(); exp_res_err.delete();
        exp_done.delete(); exp_sh_rise.delete();
        sh_cnt = 0;
    endtask

    task automatic compare_all(input int last_done);
        check_val("n_start", act_start_cyc.size(), exp_start_cyc.size());
        for (int i = 0; i < act_start_cyc.size() && i < exp_start_cyc.size(); i++) begin
            check_val("start_cyc", act_start_cyc[i], exp_start_cyc[i]);
            check_val("start_ch", act_start_ch[i], exp_start_ch[i]);
        end
        check_val("n_result", act_res_cyc.size(), exp_res_cyc.size());
        for (int i = 0; i < act_res_cyc.size() && i < exp_res_cyc.size(); i++) begin
            check_val("res_cyc", act_res_cyc[i], exp_res_cyc[i]);
            check_val("res_ch", act_res_ch[i], exp_res_ch[i]);
            check_val("res_data", act_res_data[i], exp_res_data[i]);
            check_val("res_err", act_res_err[i], exp_res_err[i]);
        end
        check_val("n_done", act_done.size(), exp_done.size());
        for (int i = 0; i < act_done.size() && i < exp_done.size(); i++)
            check_val("done_cyc", act_done[i], exp_done[i]);
        check_val("n_sh_rise", act_sh_rise.size(), exp_sh_rise.size());
        for (int i = 0; i < act_sh_rise.size() && i < exp_sh_rise.size(); i++)
            check_val("sh_rise_cyc", act_sh_rise[i], exp_sh_rise[i]);
        check_val("sh_cycles", sh_cnt, SETTLE * exp_start_cyc.size());
        check_val("n_busy_fall", act_busy_fall.size(), 1);
        if (act_busy_fall.size() > 0) check_val("busy_fall_cyc", act_busy_fall[0], last_done + 1);
        check_val("busy_end", busy, 0);
    endtask

    // Trigger a scan (or n_scans back-to-back in cont_mode) and check it.
    task automatic run_scan(input logic [NUM_CH-1:0] m, input bit cont, input int n_scans, input int mid_off);
        int c;
        int cb;
        int d;
        int drop_cyc;
        clear_all();
        @(negedge clk);
        ch_enable = m;
        cont_mode = cont;
        trig      = 1'b1;
        c         = cyc;
        cb        = c;
        drop_cyc  = -1;
        for (int k = 0; k < n_scans; k++) begin
            if (cont && k == n_scans - 1) drop_cyc = cb + 2;
            model_scan(cb, m, d);
            cb = d;
        end
        while (cyc < cb + 3) begin
            @(negedge clk);
            trig = (mid_off != 0 && cyc == c + mid_off);
            if (trig) ch_enable = ~m;
            if (cyc == drop_cyc) cont_mode = 1'b0;
        end
        trig = 1'b0;
        compare_all(cb);
    endtask

    task automatic check_outputs_zero(input string tag);
        check_val({tag, "_mux_sel"}, mux_sel, 0);
        check_val({tag, "_sample_hold"}, sample_hold, 0);
        check_val({tag, "_sar_start"}, sar_start, 0);
        check_val({tag, "_busy"}, busy, 0);
        check_val({tag, "_result_valid"}, result_valid, 0);
        check_val({tag, "_result_ch"}, result_ch, 0);
        check_val({tag, "_result_data"}, result_data, 0);
        check_val({tag, "_result_err"}, result_err, 0);
        check_val({tag, "_scan_done"}, scan_done, 0);
        check_val({tag, "_overrun"}, overrun, 0);
    endtask

    initial begin
        int c;
        rst       = 1'b1;
        trig      = 1'b0;
        cont_mode = 1'b0;
        ch_enable = '0;
        sar_eoc   = 1'b0;
        sar_data  = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            lat_tab[i] = 12;
            dat_tab[i] = '0;
        end
        repeat (3) @(negedge clk);
        check_outputs_zero("rst");
        rst = 1'b0;
        repeat (2) @(negedge clk);
        check_outputs_zero("post_rst");

        // Directed three-channel scan.
        dat_tab[0] = 10'h155; dat_tab[1] = 10'h2AA; dat_tab[2] = 10'h0AB; dat_tab[3] = 10'h3FF;
        run_scan(4'b1011, 1'b0, 1, 0);
        $display("scan mask=1011 results=%0d", act_res_cyc.size());

        // Empty mask: scan_done only.
        run_scan(4'b0000, 1'b0, 1, 0);
        $display("scan mask=0000 done=%0d", act_done.size());

        // Core never answers on ch2.
        lat_tab[2] = 0;
        run_scan(4'b0100, 1'b0, 1, 0);
        $display("scan mask=0100 timeout results=%0d", act_res_cyc.size());

        // Latency boundaries: eoc in the timeout cycle, and eoc right away.
        lat_tab[0] = 1; lat_tab[1] = TMO; lat_tab[2] = 12;
        run_scan(4'b0011, 1'b0, 1, 0);
        $display("scan mask=0011 boundary latencies");

        // Mid-scan trig and mask change.
        check_val("overrun_before", overrun, 0);
        lat_tab[1] = 7; lat_tab[2] = 9;
        run_scan(4'b0110, 1'b0, 1, 3);
        check_val("overrun_after", overrun, 1);
        $display("scan mask=0110 with mid-scan trig overrun=%0d", overrun);

        // Continuous mode, three back-to-back scans.
        lat_tab[0] = 5;
        run_scan(4'b0001, 1'b1, 3, 0);
        $display("cont scans done=%0d", act_done.size());

        // Randomized scans with spurious eoc pulses during acquisition.
        spur_en = 1'b1;
        for (int n = 0; n < 10; n++) begin
            logic [NUM_CH-1:0] m;
            m = NUM_CH'($urandom);
            for (int i = 0; i < NUM_CH; i++) begin
                lat_tab[i] = ($urandom_range(0, 7) == 0) ? 0 : int'($urandom_range(1, TMO));
                dat_tab[i] = DATA_W'($urandom);
            end
            run_scan(m, 1'b0, 1, 0);
            $display("random scan %0d mask=%b results=%0d", n, m, act_res_cyc.size());
        end
        spur_en = 1'b0;

        // Reset during CONVERT, then restart from the lowest enabled channel.
        for (int i = 0; i < NUM_CH; i++) lat_tab[i] = 20;
        @(negedge clk);
        ch_enable = 4'b1110;
        trig      = 1'b1;
        c         = cyc;
        @(negedge clk);
        trig = 1'b0;
        while (cyc < c + SETTLE + 5) @(negedge clk);
        check_val("pre_rst_busy", busy, 1);
        rst = 1'b1;
        #1;
        check_outputs_zero("async_rst");
        repeat (2) @(negedge clk);
        rst = 1'b0;
        run_scan(4'b1110, 1'b0, 1, 0);
        $display("scan after reset first_ch=%0d", act_start_ch.size() > 0 ? act_start_ch[0] : -1);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
